// File: rtl/ov7670_frame_tx.sv
// ov7670_frame_tx
//   Generates an OV7670-style camera stream (VSYNC / HREF / 8-bit data) from
//   a ready/valid RGB444 pixel source. Each pixel becomes two bytes:
//   {4'h0,R} then {G,B}. Line period L = 2*IMG_WIDTH + HBLANK clocks.
//   Frame: VSYNC_LINES*L clocks with vsync high, VBP_LINES*L of back porch,
//   IMG_HEIGHT active lines, VFP_LINES*L of front porch.
//
// Ports
//   clk          clock, all outputs registered on its rising edge
//   rst_n        asynchronous active-low reset
//   enable       permission to start a new frame (sampled at IDLE / VFP exit)
//   px_valid     px_data holds a pixel
//   px_ready     pixel accepted this cycle (one cycle before each R byte)
//   px_data      RGB444 pixel {R,G,B}
//   vsync        camera VSYNC, active high
//   href         camera HREF, high during active bytes
//   d            camera data byte
//   underflow    sticky: a pixel was needed while px_valid was low
//   frame_count  completed frames, wraps at 16 bits
module ov7670_frame_tx #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [11:0] px_data,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        underflow,
  output logic [15:0] frame_count
);

  localparam int L         = 2 * IMG_WIDTH + HBLANK;
  localparam int ACT_BYTES = 2 * IMG_WIDTH;
  localparam int LINE_MAX  = (VSYNC_LINES > VBP_LINES) ?
                             ((VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES) :
                             ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);
  localparam int BYTE_W    = (L > 1) ? $clog2(L) : 1;
  localparam int LINE_W    = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [BYTE_W-1:0] LINE_LAST  = BYTE_W'(L - 1);
  localparam logic [BYTE_W-1:0] ACT_LAST   = BYTE_W'(ACT_BYTES - 1);
  localparam logic [BYTE_W-1:0] HB_LAST    = BYTE_W'(HBLANK - 1);
  localparam logic [LINE_W-1:0] VSYNC_LAST = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VBP_LAST   = LINE_W'(VBP_LINES - 1);
  localparam logic [LINE_W-1:0] VFP_LAST   = LINE_W'(VFP_LINES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
  } state_e;

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               frame_done;
  logic               line_end;

  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic               px_ready_q, px_ready_d;
  logic [7:0]         d_q, d_d;
  logic [7:0]         gb_q, gb_d;
  logic               underflow_q, underflow_d;
  logic [15:0]        frame_count_q;
  logic               take;

  // State and counter register plus registered outputs.
  // The output registers decode the current state, so the visible stream
  // trails the FSM by one clock; this gives px_ready a full cycle of lead
  // over the byte it requests while keeping every output a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      row_q         <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      px_ready_q    <= 1'b0;
      d_q           <= 8'h00;
      gb_q          <= 8'h00;
      underflow_q   <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      row_q       <= row_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      px_ready_q  <= px_ready_d;
      d_q         <= d_d;
      gb_q        <= gb_d;
      underflow_q <= underflow_d;
      if (frame_done) begin
        frame_count_q <= frame_count_q + 16'h0001;
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q + 1'b1;
    line_cnt_d = line_cnt_q;
    row_d      = row_q;
    frame_done = 1'b0;
    line_end   = (byte_cnt_q == LINE_LAST);

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        if (enable) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (line_end) begin
          if (line_cnt_q == VSYNC_LAST) begin
            state_d = S_VBP;
          end else begin
            byte_cnt_d = '0;
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      S_VBP: begin
        row_d = '0;
        if (line_end) begin
          if (line_cnt_q == VBP_LAST) begin
            state_d = S_ACTIVE;
          end else begin
            byte_cnt_d = '0;
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (byte_cnt_q == ACT_LAST) state_d = S_HBLANK;
      end
      S_HBLANK: begin
        if (byte_cnt_q == HB_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = S_VFP;
          end else begin
            state_d = S_ACTIVE;
            row_d   = row_q + 1'b1;
          end
        end
      end
      S_VFP: begin
        if (line_end) begin
          if (line_cnt_q == VFP_LAST) begin
            frame_done = 1'b1;
            // enable is only consulted here, so frames are never cut short
            state_d    = enable ? S_VSYNC : S_IDLE;
          end else begin
            byte_cnt_d = '0;
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // every state entry restarts the per-state counters
    if (state_d != state_q) begin
      byte_cnt_d = '0;
      line_cnt_d = '0;
    end
  end

  // Output next-values (registered above)
  always_comb begin
    vsync_d     = (state_q == S_VSYNC);
    href_d      = (state_q == S_ACTIVE);
    // request a pixel when the FSM is about to sit on an even byte
    px_ready_d  = (state_d == S_ACTIVE) && !byte_cnt_d[0];
    take        = px_ready_q && px_valid;
    d_d         = 8'h00;
    gb_d        = gb_q;
    underflow_d = underflow_q | (px_ready_q & ~px_valid);

    if (state_q == S_ACTIVE) begin
      if (!byte_cnt_q[0]) begin
        // a missing pixel is sent as two zero bytes; timing never stalls
        d_d  = take ? {4'h0, px_data[11:8]} : 8'h00;
        gb_d = take ? px_data[7:0] : 8'h00;
      end else begin
        d_d  = gb_q;
      end
    end
  end

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign px_ready    = px_ready_q;
  assign d           = d_q;
  assign underflow   = underflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_frame_tx.sv
// Directed bench for ov7670_frame_tx with a 4x2 image, HBLANK=3 and one line
// of each blanking region: L = 11, frame = 55 clocks. After enable is sampled
// on edge E0, output cycle c (0-based) follows edge E(c+1):
//   vsync c=0..10, href c=22..29 and 33..40, px_ready one cycle before each
//   even byte, frame_count increments at c=54.
module tb_ov7670_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        px_valid = 1'b0;
  logic [11:0] px_data = 12'h000;
  logic        px_ready;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        underflow;
  logic [15:0] frame_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] efc;
  logic        euf;
  logic [10:0] ev;

  always #5 clk = ~clk;

  ov7670_frame_tx #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .HBLANK(3),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .vsync(vsync), .href(href), .d(d),
    .underflow(underflow), .frame_count(frame_count)
  );

  // Expected {vsync,href,px_ready,d} for frame cycle c; bad = index of a
  // line-0 pixel that was not valid (-1 for none).
  function automatic logic [10:0] exp_vec(input int c, input int bad);
    int cc, pos, ln;
    logic vs, hr, rd;
    logic [7:0] dd;
    cc = c % 55; vs = (cc < 11); hr = 1'b0; rd = 1'b0; dd = 8'h00; pos = 0; ln = 0;
    if (cc >= 22 && cc <= 29) begin hr = 1'b1; pos = cc - 22; ln = 0; end
    else if (cc >= 33 && cc <= 40) begin hr = 1'b1; pos = cc - 33; ln = 1; end
    if (hr) begin
      if (ln == 0 && pos / 2 == bad) dd = 8'h00;
      else dd = (pos % 2 == 0) ? 8'h0A : 8'hBC;
    end
    if ((cc >= 21 && cc <= 27 && (cc - 21) % 2 == 0) ||
        (cc >= 32 && cc <= 38 && (cc - 32) % 2 == 0)) rd = 1'b1;
    return {vs, hr, rd, dd};
  endfunction

  task automatic test_reset();
    #3;
    n_vec++; if ({vsync, href, px_ready, d} !== 11'h000) begin n_err++;
      $display("FAIL reset_outs act=%h exp=%h", {vsync, href, px_ready, d}, 11'h000); end
    n_vec++; if (frame_count !== 16'h0000) begin n_err++;
      $display("FAIL reset_fc act=%h exp=0000", frame_count); end
    n_vec++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL reset_uf act=%b exp=0", underflow); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if ({vsync, href, px_ready, d} !== 11'h000) begin n_err++;
        $display("FAIL idle_hold i=%0d act=%h exp=000", i, {vsync, href, px_ready, d}); end
    end
    $display("test_reset done");
  endtask

  task automatic test_continuous();
    px_data = 12'hABC; px_valid = 1'b1;
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    efc = 16'd0;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); @(negedge clk);
      if (c % 55 == 54) efc = efc + 16'd1;
      ev = exp_vec(c, -1);
      n_vec++; if ({vsync, href, px_ready, d} !== ev) begin n_err++;
        $display("FAIL cont_vec c=%0d act=%h exp=%h", c, {vsync, href, px_ready, d}, ev); end
      n_vec++; if (frame_count !== efc) begin n_err++;
        $display("FAIL cont_fc c=%0d act=%0d exp=%0d", c, frame_count, efc); end
      n_vec++; if (underflow !== 1'b0) begin n_err++;
        $display("FAIL cont_uf c=%0d act=%b exp=0", c, underflow); end
    end
    $display("test_continuous done, frame_count=%0d", frame_count);
  endtask

  // Continues straight from the previous frame; pixel 2 of line 0 is missing
  // and enable is dropped mid-frame, which must not cut the frame short.
  task automatic test_underflow();
    for (int c = 0; c < 55; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 54) efc = efc + 16'd1;
      euf = (c >= 26);
      ev = exp_vec(c, 2);
      n_vec++; if ({vsync, href, px_ready, d} !== ev) begin n_err++;
        $display("FAIL uf_vec c=%0d act=%h exp=%h", c, {vsync, href, px_ready, d}, ev); end
      n_vec++; if (frame_count !== efc) begin n_err++;
        $display("FAIL uf_fc c=%0d act=%0d exp=%0d", c, frame_count, efc); end
      n_vec++; if (underflow !== euf) begin n_err++;
        $display("FAIL uf_flag c=%0d act=%b exp=%b", c, underflow, euf); end
      px_valid = (c != 25);
      if (c == 10) enable = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if ({vsync, href, px_ready, d} !== 11'h000 || underflow !== 1'b1) begin n_err++;
        $display("FAIL uf_idle i=%0d act=%h uf=%b exp=000 uf=1", i, {vsync, href, px_ready, d}, underflow); end
    end
    $display("test_underflow done");
  endtask

  task automatic test_enable_pulse();
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    @(negedge clk); enable = 1'b0;
    for (int c = 0; c < 55; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 54) efc = efc + 16'd1;
      ev = exp_vec(c, -1);
      n_vec++; if ({vsync, href, px_ready, d} !== ev) begin n_err++;
        $display("FAIL pulse_vec c=%0d act=%h exp=%h", c, {vsync, href, px_ready, d}, ev); end
      n_vec++; if (frame_count !== efc) begin n_err++;
        $display("FAIL pulse_fc c=%0d act=%0d exp=%0d", c, frame_count, efc); end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if ({vsync, href, px_ready, d} !== 11'h000 || frame_count !== efc) begin n_err++;
        $display("FAIL pulse_idle i=%0d act=%h fc=%0d exp=000 fc=%0d", i, {vsync, href, px_ready, d}, frame_count, efc); end
    end
    $display("test_enable_pulse done");
  endtask

  task automatic test_reset_midline();
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vec(c, -1);
      n_vec++; if ({vsync, href, px_ready, d} !== ev) begin n_err++;
        $display("FAIL pre_rst_vec c=%0d act=%h exp=%h", c, {vsync, href, px_ready, d}, ev); end
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({vsync, href, px_ready, d} !== 11'h000) begin n_err++;
      $display("FAIL rst_mid_outs act=%h exp=000", {vsync, href, px_ready, d}); end
    n_vec++; if (frame_count !== 16'h0000 || underflow !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_regs fc=%0d uf=%b exp fc=0 uf=0", frame_count, underflow); end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    efc = 16'd0;
    for (int c = 0; c < 55; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 54) efc = efc + 16'd1;
      ev = exp_vec(c, -1);
      n_vec++; if ({vsync, href, px_ready, d} !== ev) begin n_err++;
        $display("FAIL post_rst_vec c=%0d act=%h exp=%h", c, {vsync, href, px_ready, d}, ev); end
      n_vec++; if (frame_count !== efc || underflow !== 1'b0) begin n_err++;
        $display("FAIL post_rst_regs c=%0d fc=%0d uf=%b exp fc=%0d uf=0", c, frame_count, underflow, efc); end
      if (c == 10) enable = 1'b0;
    end
    $display("test_reset_midline done");
  endtask

  task automatic test_fc_wrap();
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(posedge clk); @(negedge clk);
    n_vec++; if (frame_count !== 16'hFFFF) begin n_err++;
      $display("FAIL wrap_preset act=%h exp=ffff", frame_count); end
    efc = 16'hFFFF;
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    @(negedge clk); enable = 1'b0;
    for (int c = 0; c < 55; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 54) efc = 16'h0000;
      n_vec++; if (frame_count !== efc) begin n_err++;
        $display("FAIL wrap_fc c=%0d act=%h exp=%h", c, frame_count, efc); end
    end
    $display("test_fc_wrap done");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_underflow();
    test_enable_pulse();
    test_reset_midline();
    test_fc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
